// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - automatic player: watches the game's LED sequence, then replays it on the buttons.
// Optional JOGADOR_ERRO_PROPOSITAL_EN: input errar rotates the last press of each replay to force a wrong move.
module jogador_automatico #(
    parameter int DEPTH          = 16,
    parameter int QUIET_CYCLES   = 8,
    parameter int PRESS_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     habilitar,
    input  logic [3:0]               leds,
    input  logic                     ganhou,
    input  logic                     perdeu,
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
    input  logic                     errar,
`endif
    output logic                     jogar,
    output logic [3:0]               botoes,
    output logic [$clog2(DEPTH):0]   tamanho,
    output logic                     erro,
    output logic                     fim,
    output logic [3:0]               db_estado
);
    localparam int PW   = $clog2(DEPTH);
    localparam int TW   = PW + 1;
    localparam int QW   = $clog2(QUIET_CYCLES + 1);
    localparam int TMAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int TMW  = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        INICIA  = 4'h1,
        OBSERVA = 4'h2,
        APERTA  = 4'h3,
        SOLTA   = 4'h4,
        FIM     = 4'h5,
        ERRO    = 4'hE
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [3:0]      leds_ant_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]   tamanho_q, tamanho_d;
    logic [QW-1:0]   quiet_q, quiet_d;
    logic [TMW-1:0]  timer_q, timer_d;
    logic [3:0]      mem_q [DEPTH];
    logic            mem_we;
    logic            captura, um_quente, fim_jogo, ultimo;
    logic [3:0]      dado;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
    logic            errar_q, errar_d;
`endif

    assign captura   = (leds != 4'd0) && (leds_ant_q == 4'd0);
    assign um_quente = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);
    assign fim_jogo  = ganhou | perdeu;
    assign ultimo    = (TW'(rd_ptr_q) + TW'(1)) == tamanho_q;

    always_comb begin
        estado_d  = estado_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tamanho_d = tamanho_q;
        quiet_d   = quiet_q;
        timer_d   = timer_q;
        mem_we    = 1'b0;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        errar_d   = errar_q;
`endif
        case (estado_q)
            OCIOSO: if (habilitar) estado_d = INICIA;
            INICIA: begin
                wr_ptr_d  = '0;
                tamanho_d = '0;
                quiet_d   = '0;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
                errar_d   = errar;
`endif
                estado_d  = OBSERVA;
            end
            OBSERVA: begin
                if (fim_jogo) begin
                    estado_d = FIM;
                end else if (captura) begin
                    quiet_d = '0;
                    if (!um_quente || tamanho_q == TW'(DEPTH)) begin
                        estado_d = ERRO;
                    end else begin
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PW'(1);
                        tamanho_d = tamanho_q + TW'(1);
                    end
                end else if (leds != 4'd0) begin
                    quiet_d = '0;
                end else if (tamanho_q != '0) begin
                    if (quiet_q == QW'(QUIET_CYCLES - 1)) begin
                        quiet_d  = '0;
                        rd_ptr_d = '0;
                        timer_d  = '0;
                        estado_d = APERTA;
                    end else begin
                        quiet_d = quiet_q + QW'(1);
                    end
                end
            end
            APERTA: begin
                if (fim_jogo) begin
                    estado_d = FIM;
                end else if (timer_q == TMW'(PRESS_CYCLES - 1)) begin
                    timer_d  = '0;
                    estado_d = SOLTA;
                end else begin
                    timer_d = timer_q + TMW'(1);
                end
            end
            SOLTA: begin
                if (fim_jogo) begin
                    estado_d = FIM;
                end else if (timer_q == TMW'(RELEASE_CYCLES - 1)) begin
                    timer_d = '0;
                    if (ultimo) begin
                        wr_ptr_d  = '0;
                        tamanho_d = '0;
                        quiet_d   = '0;
                        estado_d  = OBSERVA;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        estado_d = APERTA;
                    end
                end else begin
                    timer_d = timer_q + TMW'(1);
                end
            end
            FIM:     estado_d = FIM;
            ERRO:    estado_d = ERRO;
            default: estado_d = OCIOSO;
        endcase
        // Dropping habilitar abandons the round from anywhere except ERRO.
        if (!habilitar && estado_q != ERRO) begin
            estado_d  = OCIOSO;
            tamanho_d = '0;
            wr_ptr_d  = '0;
            quiet_d   = '0;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            leds_ant_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tamanho_q  <= '0;
            quiet_q    <= '0;
            timer_q    <= '0;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
            errar_q    <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            leds_ant_q <= leds;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tamanho_q  <= tamanho_d;
            quiet_q    <= quiet_d;
            timer_q    <= timer_d;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
            errar_q    <= errar_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[wr_ptr_q] <= leds;
    end

    always_comb begin
        dado = mem_q[rd_ptr_q];
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        if (errar_q && ultimo) dado = {dado[2:0], dado[3]};
`endif
    end

    // Buttons decode straight from the state so reset or a game end releases them without delay.
    assign botoes    = (estado_q == APERTA) ? dado : 4'd0;
    assign jogar     = (estado_q == INICIA);
    assign tamanho   = tamanho_q;
    assign erro      = (estado_q == ERRO);
    assign fim       = (estado_q == FIM);
    assign db_estado = estado_q;
endmodule
